// File: rtl/core_pkg.sv
// Shared RV32I decode constants: opcodes, funct3/funct7 codes, immediate
// formats, flag bit positions and per-format register-field usage.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MB   = 3'b000;
    localparam logic [2:0] F3_MH   = 3'b001;
    localparam logic [2:0] F3_MW   = 3'b010;
    localparam logic [2:0] F3_MBU  = 3'b100;
    localparam logic [2:0] F3_MHU  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SH
    } imm_fmt_e;

    // Bit positions in the internal one-hot flag vector, in output port order.
    localparam int NUM_FLAGS = 33;
    localparam int FL_ADDI  = 0;
    localparam int FL_SLTI  = 1;
    localparam int FL_SLTIU = 2;
    localparam int FL_XORI  = 3;
    localparam int FL_ORI   = 4;
    localparam int FL_ANDI  = 5;
    localparam int FL_SLLI  = 6;
    localparam int FL_SRLI  = 7;
    localparam int FL_SRAI  = 8;
    localparam int FL_ADD   = 9;
    localparam int FL_SUB   = 10;
    localparam int FL_SLL   = 11;
    localparam int FL_SLT   = 12;
    localparam int FL_SLTU  = 13;
    localparam int FL_XOR   = 14;
    localparam int FL_SRL   = 15;
    localparam int FL_SRA   = 16;
    localparam int FL_OR    = 17;
    localparam int FL_AND   = 18;
    localparam int FL_BEQ   = 19;
    localparam int FL_BNE   = 20;
    localparam int FL_BLT   = 21;
    localparam int FL_BGE   = 22;
    localparam int FL_BLTU  = 23;
    localparam int FL_BGEU  = 24;
    localparam int FL_LB    = 25;
    localparam int FL_LH    = 26;
    localparam int FL_LW    = 27;
    localparam int FL_LBU   = 28;
    localparam int FL_LHU   = 29;
    localparam int FL_SB    = 30;
    localparam int FL_SH    = 31;
    localparam int FL_SW    = 32;

    function automatic logic fmt_has_rd(input imm_fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_SH) ||
               (fmt == FMT_U) || (fmt == FMT_J);
    endfunction

    function automatic logic fmt_has_rs1(input imm_fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_SH) ||
               (fmt == FMT_S) || (fmt == FMT_B);
    endfunction

    function automatic logic fmt_has_rs2(input imm_fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    endfunction

endpackage

// File: rtl/core_decode_if.sv
// Decoder-to-immediate-generator channel: selected format plus the
// instruction bits that carry immediate fields (the opcode stays in the decoder).
interface core_decode_if;
    import core_pkg::*;

    imm_fmt_e     fmt;
    logic [31:7]  inst;
    logic [31:0]  imm;

    modport master (output fmt, output inst, input  imm);
    modport slave  (input  fmt, input  inst, output imm);
endinterface

// File: rtl/core_imm_gen.sv
// Combinational RV32I immediate generator: format + instruction bits to a
// 32-bit immediate; R-type and unrecognised formats yield zero.
module core_imm_gen
    import core_pkg::*;
(
    core_decode_if.slave dec_if
);

    logic [31:7] ib;
    logic [31:0] imm_c;

    assign ib = dec_if.inst;

    always_comb begin
        imm_c = '0;
        case (dec_if.fmt)
            FMT_I:   imm_c = {{20{ib[31]}}, ib[31:20]};
            FMT_SH:  imm_c = {27'b0, ib[24:20]};
            FMT_S:   imm_c = {{20{ib[31]}}, ib[31:25], ib[11:7]};
            FMT_B:   imm_c = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
            FMT_U:   imm_c = {ib[31:12], 12'b0};
            FMT_J:   imm_c = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

    assign dec_if.imm = imm_c;

endmodule

// File: rtl/core_decode.sv
// RV32I decode stage: combinational field/flag/immediate decode of the
// fetched word, registered once so results appear one cycle later.
module core_decode
    import core_pkg::*;
(
    input  logic        rst_n,
    input  logic        clk,
    input  logic [31:0] inst,
    output logic [4:0]  RD_NUM,
    output logic [4:0]  RS1_NUM,
    output logic [4:0]  RS2_NUM,
    output logic [31:0] IMM,
    output logic        I_ADDI,
    output logic        I_SLTI,
    output logic        I_SLTIU,
    output logic        I_XORI,
    output logic        I_ORI,
    output logic        I_ANDI,
    output logic        I_SLLI,
    output logic        I_SRLI,
    output logic        I_SRAI,
    output logic        I_ADD,
    output logic        I_SUB,
    output logic        I_SLL,
    output logic        I_SLT,
    output logic        I_SLTU,
    output logic        I_XOR,
    output logic        I_SRL,
    output logic        I_SRA,
    output logic        I_OR,
    output logic        I_AND,
    output logic        I_BEQ,
    output logic        I_BNE,
    output logic        I_BLT,
    output logic        I_BGE,
    output logic        I_BLTU,
    output logic        I_BGEU,
    output logic        I_LB,
    output logic        I_LH,
    output logic        I_LW,
    output logic        I_LBU,
    output logic        I_LHU,
    output logic        I_SB,
    output logic        I_SH,
    output logic        I_SW,
    output logic        N_INST
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    imm_fmt_e             fmt_c;
    imm_fmt_e             fmt_eff;
    logic                 illegal_c;
    logic [NUM_FLAGS-1:0] flags_c;

    logic [4:0]           rd_d,  rd_q;
    logic [4:0]           rs1_d, rs1_q;
    logic [4:0]           rs2_d, rs2_q;
    logic [31:0]          imm_d, imm_q;
    logic [NUM_FLAGS-1:0] flags_d, flags_q;
    logic                 ninst_d, ninst_q;

    core_decode_if dec_if ();

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        fmt_c     = FMT_NONE;
        illegal_c = 1'b0;
        flags_c   = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: fmt_c = FMT_U;
            OPC_JAL:            fmt_c = FMT_J;
            OPC_JALR: begin
                fmt_c = FMT_I;
                if (funct3 != 3'b000) illegal_c = 1'b1;
            end
            OPC_BRANCH: begin
                fmt_c = FMT_B;
                case (funct3)
                    F3_BEQ:  flags_c[FL_BEQ]  = 1'b1;
                    F3_BNE:  flags_c[FL_BNE]  = 1'b1;
                    F3_BLT:  flags_c[FL_BLT]  = 1'b1;
                    F3_BGE:  flags_c[FL_BGE]  = 1'b1;
                    F3_BLTU: flags_c[FL_BLTU] = 1'b1;
                    F3_BGEU: flags_c[FL_BGEU] = 1'b1;
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt_c = FMT_I;
                case (funct3)
                    F3_MB:   flags_c[FL_LB]  = 1'b1;
                    F3_MH:   flags_c[FL_LH]  = 1'b1;
                    F3_MW:   flags_c[FL_LW]  = 1'b1;
                    F3_MBU:  flags_c[FL_LBU] = 1'b1;
                    F3_MHU:  flags_c[FL_LHU] = 1'b1;
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_STORE: begin
                fmt_c = FMT_S;
                case (funct3)
                    F3_MB:   flags_c[FL_SB] = 1'b1;
                    F3_MH:   flags_c[FL_SH] = 1'b1;
                    F3_MW:   flags_c[FL_SW] = 1'b1;
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                fmt_c = FMT_I;
                case (funct3)
                    F3_ADD:  flags_c[FL_ADDI]  = 1'b1;
                    F3_SLT:  flags_c[FL_SLTI]  = 1'b1;
                    F3_SLTU: flags_c[FL_SLTIU] = 1'b1;
                    F3_XOR:  flags_c[FL_XORI]  = 1'b1;
                    F3_OR:   flags_c[FL_ORI]   = 1'b1;
                    F3_AND:  flags_c[FL_ANDI]  = 1'b1;
                    F3_SLL: begin
                        fmt_c = FMT_SH;
                        if (funct7 == F7_BASE) flags_c[FL_SLLI] = 1'b1;
                        else                   illegal_c = 1'b1;
                    end
                    default: begin
                        // Only F3_SR reaches here: SRLI/SRAI split on funct7.
                        fmt_c = FMT_SH;
                        if (funct7 == F7_BASE)     flags_c[FL_SRLI] = 1'b1;
                        else if (funct7 == F7_ALT) flags_c[FL_SRAI] = 1'b1;
                        else                       illegal_c = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                fmt_c = FMT_R;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  flags_c[FL_ADD]  = 1'b1;
                        F3_SLL:  flags_c[FL_SLL]  = 1'b1;
                        F3_SLT:  flags_c[FL_SLT]  = 1'b1;
                        F3_SLTU: flags_c[FL_SLTU] = 1'b1;
                        F3_XOR:  flags_c[FL_XOR]  = 1'b1;
                        F3_SR:   flags_c[FL_SRL]  = 1'b1;
                        F3_OR:   flags_c[FL_OR]   = 1'b1;
                        default: flags_c[FL_AND]  = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        F3_ADD:  flags_c[FL_SUB] = 1'b1;
                        F3_SR:   flags_c[FL_SRA] = 1'b1;
                        default: illegal_c = 1'b1;
                    endcase
                end else begin
                    illegal_c = 1'b1;
                end
            end
            default: illegal_c = 1'b1;
        endcase
    end

    // An illegal word collapses to FMT_NONE so indices and IMM read as zero.
    assign fmt_eff     = illegal_c ? FMT_NONE : fmt_c;
    assign dec_if.fmt  = fmt_eff;
    assign dec_if.inst = inst[31:7];

    core_imm_gen u_imm_gen (
        .dec_if (dec_if.slave)
    );

    assign rd_d    = fmt_has_rd(fmt_eff)  ? inst[11:7]  : 5'd0;
    assign rs1_d   = fmt_has_rs1(fmt_eff) ? inst[19:15] : 5'd0;
    assign rs2_d   = fmt_has_rs2(fmt_eff) ? inst[24:20] : 5'd0;
    assign imm_d   = dec_if.imm;
    assign flags_d = illegal_c ? '0 : flags_c;
    assign ninst_d = illegal_c;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            flags_q <= '0;
            ninst_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            flags_q <= flags_d;
            ninst_q <= ninst_d;
        end
    end

    assign RD_NUM  = rd_q;
    assign RS1_NUM = rs1_q;
    assign RS2_NUM = rs2_q;
    assign IMM     = imm_q;
    assign N_INST  = ninst_q;

    assign I_ADDI  = flags_q[FL_ADDI];
    assign I_SLTI  = flags_q[FL_SLTI];
    assign I_SLTIU = flags_q[FL_SLTIU];
    assign I_XORI  = flags_q[FL_XORI];
    assign I_ORI   = flags_q[FL_ORI];
    assign I_ANDI  = flags_q[FL_ANDI];
    assign I_SLLI  = flags_q[FL_SLLI];
    assign I_SRLI  = flags_q[FL_SRLI];
    assign I_SRAI  = flags_q[FL_SRAI];
    assign I_ADD   = flags_q[FL_ADD];
    assign I_SUB   = flags_q[FL_SUB];
    assign I_SLL   = flags_q[FL_SLL];
    assign I_SLT   = flags_q[FL_SLT];
    assign I_SLTU  = flags_q[FL_SLTU];
    assign I_XOR   = flags_q[FL_XOR];
    assign I_SRL   = flags_q[FL_SRL];
    assign I_SRA   = flags_q[FL_SRA];
    assign I_OR    = flags_q[FL_OR];
    assign I_AND   = flags_q[FL_AND];
    assign I_BEQ   = flags_q[FL_BEQ];
    assign I_BNE   = flags_q[FL_BNE];
    assign I_BLT   = flags_q[FL_BLT];
    assign I_BGE   = flags_q[FL_BGE];
    assign I_BLTU  = flags_q[FL_BLTU];
    assign I_BGEU  = flags_q[FL_BGEU];
    assign I_LB    = flags_q[FL_LB];
    assign I_LH    = flags_q[FL_LH];
    assign I_LW    = flags_q[FL_LW];
    assign I_LBU   = flags_q[FL_LBU];
    assign I_LHU   = flags_q[FL_LHU];
    assign I_SB    = flags_q[FL_SB];
    assign I_SH    = flags_q[FL_SH];
    assign I_SW    = flags_q[FL_SW];

endmodule

// File: tb/tb_core_decode.sv
// Bench for core_decode: vector table, random ADD/ADDI, and reset sequences,
// checked through an expected-value queue one cycle after each drive.
module tb_core_decode;
    import core_pkg::*;

    localparam int NO = -1;
    localparam int W  = 81;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        int          flag;
        logic        ninst;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [4:0]  RD_NUM, RS1_NUM, RS2_NUM;
    logic I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI;
    logic I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND;
    logic I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU;
    logic I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW;
    logic N_INST;

    logic [32:0]  obs_flags;
    logic [W-1:0] obs_v;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] exp_v;
    string        exp_name;
    vec_t         tbl[$];
    int           chk_cnt;
    int           pass_cnt;

    core_decode_if tb_if ();
    assign tb_if.inst = inst[31:7];
    assign tb_if.fmt  = FMT_NONE;

    core_decode dut (
        .rst_n(rst_n), .clk(clk), .inst(inst),
        .RD_NUM(RD_NUM), .RS1_NUM(RS1_NUM), .RS2_NUM(RS2_NUM), .IMM(tb_if.imm),
        .I_ADDI(I_ADDI), .I_SLTI(I_SLTI), .I_SLTIU(I_SLTIU), .I_XORI(I_XORI),
        .I_ORI(I_ORI), .I_ANDI(I_ANDI), .I_SLLI(I_SLLI), .I_SRLI(I_SRLI), .I_SRAI(I_SRAI),
        .I_ADD(I_ADD), .I_SUB(I_SUB), .I_SLL(I_SLL), .I_SLT(I_SLT), .I_SLTU(I_SLTU),
        .I_XOR(I_XOR), .I_SRL(I_SRL), .I_SRA(I_SRA), .I_OR(I_OR), .I_AND(I_AND),
        .I_BEQ(I_BEQ), .I_BNE(I_BNE), .I_BLT(I_BLT), .I_BGE(I_BGE),
        .I_BLTU(I_BLTU), .I_BGEU(I_BGEU),
        .I_LB(I_LB), .I_LH(I_LH), .I_LW(I_LW), .I_LBU(I_LBU), .I_LHU(I_LHU),
        .I_SB(I_SB), .I_SH(I_SH), .I_SW(I_SW),
        .N_INST(N_INST)
    );

    assign obs_flags = {I_SW, I_SH, I_SB, I_LHU, I_LBU, I_LW, I_LH, I_LB,
                        I_BGEU, I_BLTU, I_BGE, I_BLT, I_BNE, I_BEQ,
                        I_AND, I_OR, I_SRA, I_SRL, I_XOR, I_SLTU, I_SLT, I_SLL, I_SUB, I_ADD,
                        I_SRAI, I_SRLI, I_SLLI, I_ANDI, I_ORI, I_XORI, I_SLTIU, I_SLTI, I_ADDI};
    assign obs_v = {RD_NUM, RS1_NUM, RS2_NUM, tb_if.imm, obs_flags, N_INST};

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", chk_cnt);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk_exp(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm,
                                            input int flag, input logic ninst);
        logic [32:0] fl;
        fl = '0;
        if (flag >= 0) fl[flag] = 1'b1;
        return {rd, rs1, rs2, imm, fl, ninst};
    endfunction

    task automatic add_vec(input string nm, input logic [31:0] ins, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input int flag, input logic ninst);
        vec_t v;
        v.name = nm; v.inst = ins; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.flag = flag; v.ninst = ninst;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [31:0] ins,
                         input logic [W-1:0] exp, input string nm);
        @(negedge clk);
        rst_n = rst;
        inst  = ins;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Scoreboard: each drive is checked just after the following rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v    = exp_q.pop_front();
            exp_name = name_q.pop_front();
            chk_cnt++;
            if (obs_v === exp_v) pass_cnt++;
            else $display("FAIL %s: got %h expected %h", exp_name, obs_v, exp_v);
        end
    end

    initial begin
        logic [W-1:0] zero_v;
        logic [4:0]   r_rd, r_rs1, r_rs2;
        logic [11:0]  r_imm;

        chk_cnt  = 0;
        pass_cnt = 0;
        rst_n    = 1'b1;
        inst     = 32'h0;
        zero_v   = mk_exp(5'd0, 5'd0, 5'd0, 32'h0, NO, 1'b0);

        add_vec("lui",          32'hFAAAF0B7,  1, 0, 0, 32'hFAAAF000, NO,       1'b0);
        add_vec("jal",          32'h7FE991EF,  3, 0, 0, 32'h000997FE, NO,       1'b0);
        add_vec("sra",          32'h4013DAB3, 21, 7, 1, 32'h0,        FL_SRA,   1'b0);
        add_vec("sw",           32'h00602223,  0, 0, 6, 32'h4,        FL_SW,    1'b0);
        add_vec("beq_back4",    32'hFE000EE3,  0, 0, 0, 32'hFFFFFFFC, FL_BEQ,   1'b0);
        add_vec("addi_m1",      32'hFFF00093,  1, 0, 0, 32'hFFFFFFFF, FL_ADDI,  1'b0);
        add_vec("all_zero",     32'h00000000,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("auipc",        32'h12345297,  5, 0, 0, 32'h12345000, NO,       1'b0);
        add_vec("jalr",         32'h008100E7,  1, 2, 0, 32'h8,        NO,       1'b0);
        add_vec("jalr_f3",      32'h008110E7,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("lw_neg",       32'hFF822183,  3, 4, 0, 32'hFFFFFFF8, FL_LW,    1'b0);
        add_vec("load_f3_011",  32'hFF823183,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("lhu",          32'h0000D083,  1, 1, 0, 32'h0,        FL_LHU,   1'b0);
        add_vec("store_f3_011", 32'h00603223,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("sb_neg",       32'hFE740FA3,  0, 8, 7, 32'hFFFFFFFF, FL_SB,    1'b0);
        add_vec("br_f3_010",    32'hFE002EE3,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("bgeu_16",      32'h0020F863,  0, 1, 2, 32'h10,       FL_BGEU,  1'b0);
        add_vec("sub",          32'h402081B3,  3, 1, 2, 32'h0,        FL_SUB,   1'b0);
        add_vec("op_f7_01",     32'h022081B3,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("sll_alt_f7",   32'h402091B3,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("slli_alt_f7",  32'h40009093,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("slli_3",       32'h00309093,  1, 1, 0, 32'h3,        FL_SLLI,  1'b0);
        add_vec("srai_31",      32'h41F15093,  1, 2, 0, 32'h1F,       FL_SRAI,  1'b0);
        add_vec("sltiu_min",    32'h8001B113,  2, 3, 0, 32'hFFFFF800, FL_SLTIU, 1'b0);
        add_vec("low_bits_10",  32'hFFF00091,  0, 0, 0, 32'h0,        NO,       1'b1);
        add_vec("and",          32'h003170B3,  1, 2, 3, 32'h0,        FL_AND,   1'b0);
        add_vec("unk_opcode",   32'h0000007F,  0, 0, 0, 32'h0,        NO,       1'b1);

        // Reset state
        drive(1'b1, 32'h0, zero_v, "reset_a");
        drive(1'b1, 32'hFFF00093, zero_v, "reset_over_addi");

        // Table, back-to-back
        for (int i = 0; i < tbl.size(); i++) begin
            drive(1'b0, tbl[i].inst,
                  mk_exp(tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].flag, tbl[i].ninst),
                  tbl[i].name);
        end

        // Random register-register ADD and sign-extended ADDI
        for (int i = 0; i < 8; i++) begin
            r_rd  = 5'($urandom_range(0, 31));
            r_rs1 = 5'($urandom_range(0, 31));
            r_rs2 = 5'($urandom_range(0, 31));
            r_imm = 12'($urandom_range(0, 4095));
            drive(1'b0, {7'b0000000, r_rs2, r_rs1, 3'b000, r_rd, 7'b0110011},
                  mk_exp(r_rd, r_rs1, r_rs2, 32'h0, FL_ADD, 1'b0), "rand_add");
            drive(1'b0, {r_imm, r_rs1, 3'b000, r_rd, 7'b0010011},
                  mk_exp(r_rd, r_rs1, 5'd0, {{20{r_imm[11]}}, r_imm}, FL_ADDI, 1'b0), "rand_addi");
        end

        // Illegal word, then reset clears N_INST
        drive(1'b0, 32'h00000000, mk_exp(5'd0, 5'd0, 5'd0, 32'h0, NO, 1'b1), "illegal_pre_rst");
        drive(1'b1, 32'h00000000, zero_v, "reset_after_illegal");
        drive(1'b0, 32'hFAAAF0B7, mk_exp(5'd1, 5'd0, 5'd0, 32'hFAAAF000, NO, 1'b0), "lui_after_rst");
        // Reset wins over a legal flagged instruction mid-stream
        drive(1'b1, 32'h4013DAB3, zero_v, "reset_over_sra");
        drive(1'b0, 32'h00602223, mk_exp(5'd0, 5'd0, 5'd6, 32'h4, FL_SW, 1'b0), "sw_after_rst");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
